sseg_scan_arbiter: RTL and testbench
====================================

# sseg_scan_arbiter

Time-multiplexed scan controller for the 8-digit seven-segment display. It owns the digit buffer, shares its write port between two requesters (the sequence generator and a status source) through a round-robin request/grant handshake, and continuously scans the buffer onto SSEG_CA/SSEG_AN with a blanking gap between digits. It sits between the data producers and the board display pins, replacing direct drive of SSEG_* by any single producer.

## Interface
- SIM, default 0: 1 selects short simulation timing.
- DWELL, default SIM ? 4 : 100000: clk cycles each digit is lit.
- BLANK, default SIM ? 1 : 1000: clk cycles with all anodes off between digits.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  2  write request per requester; held until granted.
- wr_idx0, wr_idx1  in  3 each  target digit, 0 = rightmost (AN[0]).
- wr_val0, wr_val1  in  4 each  hex value.
- wr_dp0, wr_dp1  in  1 each  decimal point (1 = lit).
- gnt  out  2  one-hot single-cycle grant; the write commits on this cycle.
- digit_en  in  8  per-digit enable; 0 keeps that anode off during its slot.
- SSEG_CA  out  8  cathodes, active-low; [0]=a … [6]=g, [7]=DP.
- SSEG_AN  out  8  anodes, active-low, one-hot-low when lit.

## Operation
- Digit buffer: 8 entries × {val[3:0], dp}. Reset clears every entry to val 0, dp 0.
- Arbiter:
  - Sample req each cycle when no grant is pending.
  - If exactly one bit is set, grant that requester.
  - If both are set, grant the requester named by priority pointer ptr. After any grant, ptr moves to the other requester.
  - gnt is registered: req seen at edge N gives gnt high for the cycle after edge N+1. The buffer write uses that requester's wr_* inputs on the edge ending the gnt cycle.
  - Requester rules: hold wr_* stable while req is high; drop req the cycle after gnt.
  - If req is still high on the edge where gnt falls, it counts as a new request.
  - At most one write per cycle. No grant is issued on the edge where the previous gnt ends, so the maximum rate is one write per 2 cycles.
- Scan FSM states:
  - SHOW: drive AN[d]=0 if digit_en[d], else 0xFF. Drive CA=decode(buf[d]). Count DWELL cycles, then go to GAP.
  - GAP: AN=0xFF, CA=0xFF. Count BLANK cycles, then set d=d+1 mod 8 and go to SHOW.
  - From reset: enter SHOW, d=0.
- Decode (active-low, DP off), hex 0-F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E. dp=1 clears CA[7].
- A write to the digit currently in SHOW appears on CA within 1 cycle of the commit edge; the anode does not glitch.
- Reset mid-operation:
  - next edge returns d=0, SHOW, counters 0, ptr=0, gnt=0, buffer cleared.
  - A pending grant is dropped and the requester must re-request.

## Timing
- Reset values: SSEG_AN=8'hFF, SSEG_CA=8'hFF, gnt=2'b00. All outputs are registered.
- The first lit cycle is 1 cycle after reset deasserts: AN=8'hFE, CA=8'hC0.
- Scan period is 8×(DWELL+BLANK) cycles; 40 cycles with SIM=1.
- Counter widths are sized by $clog2 of DWELL and BLANK. Counters wrap exactly at their terminal count with no extra cycle.
- Request-to-commit latency: 2 cycles uncontested, 4 cycles worst case with the other requester continuously active.

## Structure
- Package sseg_pkg: scan state enum (SHOW, GAP), the hex→segment constant table, and active-low constants SEG_OFF=8'hFF and AN_OFF=8'hFF.
- Sub-module sseg_hex_decode: combinational 4-bit+dp → 8-bit CA, instantiated once on the scan read path.
- The arbiter and scan FSM live in the top module; target size is about 200 lines.

## Test plan (SIM=1)
- Reset, then idle 40 cycles: AN steps FE, FF, FD, FF, … 7F, FF and wraps to FE. CA=C0 in every SHOW slot and FF in every GAP.
- Requester 0 only writes idx 2, val 8, dp 1: gnt=01 two cycles after req. When digit 2 is in SHOW, AN=FB and CA=00.
- Both requesters request continuously with distinct idx: gnt alternates 01, 10, 01 with one idle cycle between grants. The buffer ends with both values. No cycle has gnt=11.
- digit_en=8'h0F with all digits written to 5: AN stays FF during slots 4-7, and CA=92 during slots 0-3.
- Write idx 0, val A while digit 0 is in SHOW: CA changes C0→88 one cycle after the commit edge, with AN held at FE throughout.
- Assert reset for 1 cycle during SHOW of digit 5 with a request pending: the next edge gives AN=FF, CA=FF, gnt=00, buffer cleared, and scanning restarts at digit 0.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan arbiter.
// Segment and anode constants are active-low.
package sseg_pkg;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Hex digit to cathode pattern, DP bit left off.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/sseg_scan_arbiter_if.sv
// Write-port bundle shared by the two display requesters.
// Master is the requester side, slave is the arbiter side.
interface sseg_scan_arbiter_if;

    logic [1:0] req;
    logic [2:0] wr_idx0;
    logic [2:0] wr_idx1;
    logic [3:0] wr_val0;
    logic [3:0] wr_val1;
    logic       wr_dp0;
    logic       wr_dp1;
    logic [1:0] gnt;

    modport master (
        output req,
        output wr_idx0, wr_idx1,
        output wr_val0, wr_val1,
        output wr_dp0, wr_dp1,
        input  gnt
    );

    modport slave (
        input  req,
        input  wr_idx0, wr_idx1,
        input  wr_val0, wr_val1,
        input  wr_dp0, wr_dp1,
        output gnt
    );

endinterface

// File: rtl/sseg_hex_decode.sv
// Hex value plus decimal point to active-low cathode pattern.
// Purely combinational; sits on the scan read path.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] val,
    input  logic       dp,
    output logic [7:0] seg
);

    // Table lookup, then pull DP low when lit.
    always_comb begin
        seg = HEX_SEG[val];
        if (dp) begin
            seg[7] = 1'b0;
        end
    end

endmodule

// File: rtl/sseg_scan_arbiter.sv
// Eight-digit scan controller with a round-robin shared write port.
// All display and grant outputs are registered.
module sseg_scan_arbiter
    import sseg_pkg::*;
#(
    parameter bit SIM   = 1'b0,
    parameter int DWELL = SIM ? 4 : 100000,
    parameter int BLANK = SIM ? 1 : 1000
) (
    input  logic                clk,
    input  logic                reset,
    sseg_scan_arbiter_if.slave  bus,
    input  logic [7:0]          digit_en,
    output logic [7:0]          SSEG_CA,
    output logic [7:0]          SSEG_AN
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BL_W = (BLANK > 1) ? $clog2(BLANK) : 1;
    localparam int CW   = (DW_W > BL_W) ? DW_W : BL_W;

    localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] BL_LAST = CW'(BLANK - 1);

    logic [3:0]  val_buf [8];
    logic        dp_buf  [8];

    logic [1:0]  pend;
    logic [1:0]  pick;
    logic        ptr;

    scan_state_t state;
    scan_state_t state_nx;
    logic [2:0]  digit;
    logic [2:0]  digit_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;

    logic [7:0]  seg;
    logic [7:0]  an_nx;
    logic [7:0]  ca_nx;

    // Choose a winner from the live requests; ptr breaks ties.
    always_comb begin
        pick = 2'b00;
        unique case (bus.req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = ptr ? 2'b10 : 2'b01;
            default: pick = 2'b00;
        endcase
    end

    // Two-stage grant: latch the winner, then pulse gnt for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend     <= 2'b00;
            bus.gnt  <= 2'b00;
            ptr      <= 1'b0;
        end else begin
            bus.gnt <= pend;
            if (pend != 2'b00) begin
                pend <= 2'b00;
            end else begin
                pend <= pick;
                if (pick != 2'b00) begin
                    ptr <= pick[0];
                end
            end
        end
    end

    // Digit buffer; a write lands on the edge that ends the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                val_buf[i] <= 4'h0;
                dp_buf[i]  <= 1'b0;
            end
        end else if (bus.gnt[0]) begin
            val_buf[bus.wr_idx0] <= bus.wr_val0;
            dp_buf[bus.wr_idx0]  <= bus.wr_dp0;
        end else if (bus.gnt[1]) begin
            val_buf[bus.wr_idx1] <= bus.wr_val1;
            dp_buf[bus.wr_idx1]  <= bus.wr_dp1;
        end
    end

    // Scan state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SHOW;
            digit <= 3'd0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            digit <= digit_nx;
            cnt   <= cnt_nx;
        end
    end

    // Dwell in SHOW, blank in GAP, advance the digit on leaving GAP.
    always_comb begin
        state_nx = state;
        digit_nx = digit;
        cnt_nx   = cnt + CW'(1);
        unique case (state)
            SHOW: begin
                if (cnt == DW_LAST) begin
                    state_nx = GAP;
                    cnt_nx   = '0;
                end
            end
            GAP: begin
                if (cnt == BL_LAST) begin
                    state_nx = SHOW;
                    cnt_nx   = '0;
                    digit_nx = digit + 3'd1;
                end
            end
        endcase
    end

    sseg_hex_decode u_dec (
        .val (val_buf[digit]),
        .dp  (dp_buf[digit]),
        .seg (seg)
    );

    // Pin values for the current scan position.
    always_comb begin
        an_nx = AN_OFF;
        ca_nx = SEG_OFF;
        if (state == SHOW) begin
            ca_nx = seg;
            if (digit_en[digit]) begin
                an_nx = ~(8'b1 << digit);
            end
        end
    end

    // Register the pins so they never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            SSEG_AN <= AN_OFF;
            SSEG_CA <= SEG_OFF;
        end else begin
            SSEG_AN <= an_nx;
            SSEG_CA <= ca_nx;
        end
    end

endmodule

// File: tb/tb_sseg_scan_arbiter.sv
// Scoreboard bench for sseg_scan_arbiter with SIM timing.
// Grants are matched against a queue; pins against a scan model.
module tb_sseg_scan_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] digit_en;
    logic [7:0] ca;
    logic [7:0] an;

    sseg_scan_arbiter_if bus ();

    sseg_scan_arbiter #(.SIM(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .digit_en (digit_en),
        .SSEG_CA  (ca),
        .SSEG_AN  (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [1:0] g;
    } gnt_t;

    typedef struct {
        int         at;
        int         idx;
        logic [3:0] val;
        logic       dp;
    } wr_t;

    gnt_t gq[$];
    wr_t  wq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rel   = 0;
    logic [7:0] en_s;

    logic [3:0] sh_val [8];
    logic       sh_dp  [8];

    logic [7:0] seg_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [7:0] dec(input logic [3:0] v, input logic dp);
        logic [7:0] s;
        s = seg_tab[v];
        if (dp) s[7] = 1'b0;
        return s;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edge counter, last reset edge, and digit_en as seen by each edge.
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        if (reset) rel <= cyc + 1;
        en_s <= digit_en;
    end

    // Scan model: expected pins for the edge just taken.
    always @(negedge clk) begin
        int j;
        int p;
        int d;
        logic show;
        logic [7:0] ea;
        logic [7:0] ec;
        if (cyc >= 1) begin
            while (wq.size() > 0 && wq[0].at < cyc) begin
                sh_val[wq[0].idx] = wq[0].val;
                sh_dp[wq[0].idx]  = wq[0].dp;
                void'(wq.pop_front());
            end
            j = cyc - rel;
            if (j == 0) begin
                for (int i = 0; i < 8; i++) begin
                    sh_val[i] = 4'h0;
                    sh_dp[i]  = 1'b0;
                end
                ea = 8'hFF;
                ec = 8'hFF;
            end else begin
                p    = (j - 1) % 40;
                d    = p / 5;
                show = (p % 5) < 4;
                ea   = 8'hFF;
                ec   = 8'hFF;
                if (show) begin
                    ec = dec(sh_val[d], sh_dp[d]);
                    if (en_s[d]) ea = ~(8'h01 << d);
                end
            end
            chk("an", an, ea);
            chk("ca", ca, ec);
        end
    end

    // Grant monitor: every grant pulse must match the head of the queue.
    always @(negedge clk) begin
        gnt_t e;
        if (cyc >= 1) begin
            if (gq.size() > 0 && gq[0].at < cyc) begin
                e = gq.pop_front();
                total++;
                bad++;
                $display("FAIL gnt_missing cyc=%0d got=none want=%b@%0d", cyc, e.g, e.at);
            end
            if (bus.gnt !== 2'b00) begin
                total++;
                if (gq.size() == 0) begin
                    bad++;
                    $display("FAIL gnt_unexpected cyc=%0d got=%b want=00", cyc, bus.gnt);
                end else begin
                    e = gq.pop_front();
                    if (bus.gnt !== e.g || cyc != e.at) begin
                        bad++;
                        $display("FAIL gnt cyc=%0d got=%b want=%b@%0d", cyc, bus.gnt, e.g, e.at);
                    end
                end
            end
        end
    end

    task automatic do_write(input int r, input int idx, input logic [3:0] v, input logic dp);
        int k;
        k = cyc;
        if (r == 0) begin
            bus.wr_idx0 = 3'(idx);
            bus.wr_val0 = v;
            bus.wr_dp0  = dp;
            bus.req[0]  = 1'b1;
        end else begin
            bus.wr_idx1 = 3'(idx);
            bus.wr_val1 = v;
            bus.wr_dp1  = dp;
            bus.req[1]  = 1'b1;
        end
        gq.push_back('{k + 2, (r == 0) ? 2'b01 : 2'b10});
        wq.push_back('{k + 3, idx, v, dp});
        nclk(2);
        if (r == 0) bus.req[0] = 1'b0;
        else        bus.req[1] = 1'b0;
        nclk(1);
    endtask

    task automatic wait_phase(input int ph);
        int i;
        i = 0;
        while (((cyc - rel - 1) % 40) != ph && i < 41) begin
            nclk(1);
            i++;
        end
        if (i >= 41) begin
            total++;
            bad++;
            $display("FAIL phase_wait got=%0d want=%0d", (cyc - rel - 1) % 40, ph);
        end
    endtask

    initial begin
        int k;
        reset       = 1'b1;
        digit_en    = 8'hFF;
        bus.req     = 2'b00;
        bus.wr_idx0 = 3'd0;
        bus.wr_idx1 = 3'd0;
        bus.wr_val0 = 4'h0;
        bus.wr_val1 = 4'h0;
        bus.wr_dp0  = 1'b0;
        bus.wr_dp1  = 1'b0;
        nclk(3);
        reset = 1'b0;
        nclk(44);

        // Both requesters active: 01, 10, 01, 10 with a gap between.
        k = cyc;
        bus.wr_idx0 = 3'd3; bus.wr_val0 = 4'h1; bus.wr_dp0 = 1'b0;
        bus.wr_idx1 = 3'd4; bus.wr_val1 = 4'h2; bus.wr_dp1 = 1'b1;
        bus.req = 2'b11;
        gq.push_back('{k + 2, 2'b01});
        gq.push_back('{k + 4, 2'b10});
        gq.push_back('{k + 6, 2'b01});
        gq.push_back('{k + 8, 2'b10});
        wq.push_back('{k + 3, 3, 4'h1, 1'b0});
        wq.push_back('{k + 5, 4, 4'h2, 1'b1});
        wq.push_back('{k + 7, 3, 4'h1, 1'b0});
        wq.push_back('{k + 9, 4, 4'h2, 1'b1});
        nclk(8);
        bus.req = 2'b00;
        nclk(44);

        // Lone requester 0: digit 2 shows 8 with DP.
        do_write(0, 2, 4'h8, 1'b1);
        nclk(42);

        // Commit to digit 0 while it is lit.
        wait_phase(38);
        do_write(0, 0, 4'hA, 1'b0);
        nclk(42);

        // All digits to 5, upper four disabled.
        for (int i = 0; i < 8; i++) begin
            do_write(i % 2, i, 4'h5, 1'b0);
        end
        digit_en = 8'h0F;
        nclk(45);

        // Reset during digit 5 with a request already latched.
        wait_phase(26);
        bus.wr_idx0 = 3'd1;
        bus.wr_val0 = 4'h7;
        bus.wr_dp0  = 1'b0;
        bus.req[0]  = 1'b1;
        nclk(1);
        reset = 1'b1;
        nclk(1);
        reset    = 1'b0;
        bus.req  = 2'b00;
        digit_en = 8'hFF;
        nclk(42);

        // Pointer restarts at requester 0 after reset.
        k = cyc;
        bus.wr_idx0 = 3'd6; bus.wr_val0 = 4'h3; bus.wr_dp0 = 1'b0;
        bus.wr_idx1 = 3'd7; bus.wr_val1 = 4'hE; bus.wr_dp1 = 1'b0;
        bus.req = 2'b11;
        gq.push_back('{k + 2, 2'b01});
        gq.push_back('{k + 4, 2'b10});
        wq.push_back('{k + 3, 6, 4'h3, 1'b0});
        wq.push_back('{k + 5, 7, 4'hE, 1'b0});
        nclk(2);
        bus.req[0] = 1'b0;
        nclk(2);
        bus.req[1] = 1'b0;
        nclk(44);

        total++;
        if (gq.size() != 0) begin
            bad++;
            $display("FAIL gnt_left got=%0d want=0", gq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
